cmd_cfg: RTL and testbench
==========================

# cmd_cfg

Command decoder/configuration stage of the QuadCopter. Consumes the assembled 24-bit host command (`cmd` + `data`, qualified by `cmd_rdy`) from the UART wrapper. Holds the flight setpoints (`d_ptch`, `d_roll`, `d_yaw`, `thrst`) for the flight controller and sequences motor spin-up and inertial calibration. Returns a one-byte acknowledge to the host for every accepted command.

## Interface
Parameters:
- none (timer width selected by macro, see Configuration)

Ports:
- `clk`  in  1  system clock, single clock domain
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_rdy`  in  1  command valid from UART wrapper; held until cleared
- `cmd`  in  8  opcode
- `data`  in  16  operand
- `clr_cmd_rdy`  out  1  one-cycle pulse; consumes current command
- `resp`  out  8  response byte (0xA5 ack, 0xEE nack)
- `send_resp`  out  1  one-cycle pulse; `resp` valid in the same cycle
- `cal_done`  in  1  inertial interface finished calibration
- `strt_cal`  out  1  one-cycle pulse; start inertial calibration
- `inertial_cal`  out  1  high throughout motor ramp and calibration
- `d_ptch`, `d_roll`, `d_yaw`  out  16  signed setpoints
- `thrst`  out  9  unsigned thrust
- `motors_off`  out  1  forces ESCs off

## Operation
- Opcodes: 0x02 SET_PITCH, 0x03 SET_ROLL, 0x04 SET_YAW, 0x05 SET_THRST, 0x06 CALIBRATE, 0x07 E_LAND, 0x08 MOTORS_OFF.
- FSM states:
  - IDLE
  - RAMP: motor spin-up wait
  - CAL: waiting for `cal_done`
- IDLE, `cmd_rdy`=1:
  - Always pulse `clr_cmd_rdy`.
  - 0x02/0x03/0x04: load `data` into `d_ptch`/`d_roll`/`d_yaw`; ack.
  - 0x05: `thrst` <= `data[8:0]` (upper bits ignored); ack.
  - 0x07: `d_ptch`, `d_roll`, `d_yaw`, `thrst` <= 0; `motors_off` unchanged; ack.
  - 0x08: `motors_off` <= 1; ack.
  - 0x06: `motors_off` <= 0; clear timer; go to RAMP. No response yet.
  - Any other opcode: nothing updated; pulse `send_resp` with `resp`=0xEE.
- RAMP:
  - Timer increments every cycle; `tmr_full` = timer all-ones.
  - On `tmr_full`: go to CAL.
- CAL:
  - Wait for `cal_done`.
  - On `cal_done`: pulse `send_resp` with 0xA5; go to IDLE.
- `inertial_cal` = (state==RAMP) | (state==CAL), decoded from the state register.
- `strt_cal` = (state==RAMP) & `tmr_full` (Mealy), so exactly one cycle per calibration.
- `cmd_rdy` seen in RAMP/CAL is neither cleared nor decoded; it is processed on return to IDLE.
- Timer counts only in RAMP and is cleared on entry, so no wrap-around is possible.

## Timing
- Reset values:
  - state=IDLE; `d_ptch`=`d_roll`=`d_yaw`=0; `thrst`=0; `motors_off`=1
  - `strt_cal`=`inertial_cal`=`clr_cmd_rdy`=`send_resp`=0; `resp`=0xA5; timer=0
- Setpoint commands:
  - `cmd_rdy` sampled high at edge N → register updated after edge N.
  - `clr_cmd_rdy` and `send_resp` are combinational from that same IDLE cycle.
  - Ack latency is 1 cycle.
- CALIBRATE:
  - `inertial_cal` high from edge N+1.
  - `strt_cal` high for the single cycle in which `tmr_full`=1; CAL entered at the following edge.
  - `inertial_cal` low in the cycle after `cal_done` is sampled.
- Setpoints are held stable during RAMP/CAL.
- Asynchronous reset mid-calibration: immediate return to reset values; no response is issued.
- `cal_done` asserted outside CAL is ignored.

## Configuration
- `FAST_SIM_EN` defined: timer is 9 bits (`tmr_full` after 511 cycles in RAMP), for simulation.
- Undefined: timer is 26 bits (~1.34 s at 50 MHz) for hardware.

## Test plan
- Reset, then SET_THRST data=0x00AA → `thrst`=0x0AA, `resp`=0xA5 with one `send_resp` pulse, `clr_cmd_rdy` pulsed once.
- SET_PITCH 0xFF9C, SET_ROLL 0x0066, SET_YAW 0x0099 → `d_ptch`=-100, `d_roll`=0x0066, `d_yaw`=0x0099; three acks.
- CALIBRATE (with FAST_SIM_EN) → `inertial_cal`=1 next cycle, `motors_off`=0, `strt_cal` single pulse 512 cycles later; drive `cal_done` 20 cycles later → `inertial_cal`=0 and ack 0xA5.
- E_LAND after nonzero setpoints → all four setpoints 0, `motors_off` unchanged, ack. Then MOTORS_OFF → `motors_off`=1, ack.
- Opcode 0x3C → `resp`=0xEE, no register change. SET_PITCH issued during RAMP → not cleared until calibration completes, then applied.
- `rst_n` low for 1 cycle in CAL → all outputs at reset values; `cal_done` afterwards produces no response.

Source files
------------

// File: rtl/cmd_cfg.sv
// cmd_cfg: decodes host commands into flight setpoints and sequences motor spin-up plus inertial calibration.
// Define FAST_SIM_EN for a 9-bit spin-up timer (simulation); otherwise the timer is 26 bits (~1.34 s at 50 MHz).
`timescale 1ns/1ps
module cmd_cfg (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_rdy,
    input  logic [7:0]         cmd,
    input  logic [15:0]        data,
    output logic               clr_cmd_rdy,
    output logic [7:0]         resp,
    output logic               send_resp,
    input  logic               cal_done,
    output logic               strt_cal,
    output logic               inertial_cal,
    output logic signed [15:0] d_ptch,
    output logic signed [15:0] d_roll,
    output logic signed [15:0] d_yaw,
    output logic [8:0]         thrst,
    output logic               motors_off
);
`ifdef FAST_SIM_EN
    localparam int TMR_W = 9;
`else
    localparam int TMR_W = 26;
`endif

    localparam logic [7:0] OP_SET_PITCH  = 8'h02;
    localparam logic [7:0] OP_SET_ROLL   = 8'h03;
    localparam logic [7:0] OP_SET_YAW    = 8'h04;
    localparam logic [7:0] OP_SET_THRST  = 8'h05;
    localparam logic [7:0] OP_CALIBRATE  = 8'h06;
    localparam logic [7:0] OP_E_LAND     = 8'h07;
    localparam logic [7:0] OP_MOTORS_OFF = 8'h08;
    localparam logic [7:0] RESP_ACK      = 8'hA5;
    localparam logic [7:0] RESP_NACK     = 8'hEE;

    typedef enum logic [1:0] {IDLE, RAMP, CAL} state_t;

    state_t                r_state;
    state_t                w_nxt_state;
    logic [TMR_W-1:0]      r_tmr;
    logic signed [15:0]    r_ptch;
    logic signed [15:0]    r_roll;
    logic signed [15:0]    r_yaw;
    logic [8:0]            r_thrst;
    logic                  r_motors_off;
    logic                  w_tmr_full;
    logic                  w_ld_ptch;
    logic                  w_ld_roll;
    logic                  w_ld_yaw;
    logic                  w_ld_thrst;
    logic                  w_eland;
    logic                  w_moff_set;
    logic                  w_moff_clr;
    logic                  w_clr_tmr;

    assign w_tmr_full = &r_tmr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nxt_state;
    end

    // Commands are only decoded in IDLE; a cmd_rdy arriving mid-calibration waits untouched.
    always_comb begin
        w_nxt_state = r_state;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        resp        = RESP_ACK;
        strt_cal    = 1'b0;
        w_ld_ptch   = 1'b0;
        w_ld_roll   = 1'b0;
        w_ld_yaw    = 1'b0;
        w_ld_thrst  = 1'b0;
        w_eland     = 1'b0;
        w_moff_set  = 1'b0;
        w_moff_clr  = 1'b0;
        w_clr_tmr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    send_resp   = 1'b1;
                    case (cmd)
                        OP_SET_PITCH:  w_ld_ptch  = 1'b1;
                        OP_SET_ROLL:   w_ld_roll  = 1'b1;
                        OP_SET_YAW:    w_ld_yaw   = 1'b1;
                        OP_SET_THRST:  w_ld_thrst = 1'b1;
                        OP_E_LAND:     w_eland    = 1'b1;
                        OP_MOTORS_OFF: w_moff_set = 1'b1;
                        OP_CALIBRATE: begin
                            send_resp   = 1'b0;
                            w_moff_clr  = 1'b1;
                            w_clr_tmr   = 1'b1;
                            w_nxt_state = RAMP;
                        end
                        default:       resp = RESP_NACK;
                    endcase
                end
            end
            RAMP: begin
                if (w_tmr_full) begin
                    strt_cal    = 1'b1;
                    w_nxt_state = CAL;
                end
            end
            CAL: begin
                if (cal_done) begin
                    send_resp   = 1'b1;
                    w_nxt_state = IDLE;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_tmr <= '0;
        else if (w_clr_tmr)        r_tmr <= '0;
        else if (r_state == RAMP)  r_tmr <= r_tmr + TMR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptch       <= '0;
            r_roll       <= '0;
            r_yaw        <= '0;
            r_thrst      <= '0;
            r_motors_off <= 1'b1;
        end else begin
            if (w_ld_ptch)  r_ptch  <= signed'(data);
            if (w_ld_roll)  r_roll  <= signed'(data);
            if (w_ld_yaw)   r_yaw   <= signed'(data);
            if (w_ld_thrst) r_thrst <= data[8:0];
            if (w_eland) begin
                r_ptch  <= '0;
                r_roll  <= '0;
                r_yaw   <= '0;
                r_thrst <= '0;
            end
            if (w_moff_set)      r_motors_off <= 1'b1;
            else if (w_moff_clr) r_motors_off <= 1'b0;
        end
    end

    assign inertial_cal = (r_state == RAMP) || (r_state == CAL);
    assign d_ptch       = r_ptch;
    assign d_roll       = r_roll;
    assign d_yaw        = r_yaw;
    assign thrst        = r_thrst;
    assign motors_off   = r_motors_off;

endmodule

// File: tb/tb_cmd_cfg.sv
// Testbench for cmd_cfg: table-driven vectors, calibration sequences and randomized commands vs. a setpoint model.
`timescale 1ns/1ps
module tb_cmd_cfg;
`ifdef FAST_SIM_EN
    localparam int RAMP_CYC = 512;
`else
    localparam int RAMP_CYC = 1;
`endif

    logic               clk;
    logic               rst_n;
    logic               cmd_rdy;
    logic [7:0]         cmd;
    logic [15:0]        data;
    logic               clr_cmd_rdy;
    logic [7:0]         resp;
    logic               send_resp;
    logic               cal_done;
    logic               strt_cal;
    logic               inertial_cal;
    logic signed [15:0] d_ptch;
    logic signed [15:0] d_roll;
    logic signed [15:0] d_yaw;
    logic [8:0]         thrst;
    logic               motors_off;

    cmd_cfg dut (
        .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
        .cal_done(cal_done), .strt_cal(strt_cal), .inertial_cal(inertial_cal),
        .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw), .thrst(thrst),
        .motors_off(motors_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    int         n_send = 0;
    int         n_clr = 0;
    int         n_strt = 0;
    int         s0, c0, t0;
    logic [7:0] last_resp = 8'h00;

    // Reference state: what the setpoints should be after each accepted command.
    logic [15:0] m_ptch, m_roll, m_yaw;
    logic [8:0]  m_thr;
    logic        m_moff;

    always @(negedge clk) begin
        if (send_resp) begin
            n_send++;
            last_resp = resp;
        end
        if (clr_cmd_rdy) n_clr++;
        if (strt_cal)    n_strt++;
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptch = '0; m_roll = '0; m_yaw = '0; m_thr = '0; m_moff = 1'b1;
    endtask

    task automatic model_cmd(input logic [7:0] op, input logic [15:0] d, output logic [7:0] er);
        er = 8'hA5;
        case (op)
            8'h02: m_ptch = d;
            8'h03: m_roll = d;
            8'h04: m_yaw  = d;
            8'h05: m_thr  = d[8:0];
            8'h07: begin m_ptch = '0; m_roll = '0; m_yaw = '0; m_thr = '0; end
            8'h08: m_moff = 1'b1;
            default: er = 8'hEE;
        endcase
    endtask

    task automatic apply(input logic [7:0] op, input logic [15:0] d);
        s0 = n_send; c0 = n_clr;
        @(posedge clk); #1;
        cmd_rdy = 1'b1; cmd = op; data = d;
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
    endtask

    task automatic chk_model(input string pfx, input logic [7:0] er);
        chk({pfx, "_resp"}, 16'(last_resp), 16'(er));
        chk({pfx, "_send_cnt"}, 16'(n_send - s0), 16'd1);
        chk({pfx, "_clr_cnt"}, 16'(n_clr - c0), 16'd1);
        chk({pfx, "_ptch"}, 16'(d_ptch), m_ptch);
        chk({pfx, "_roll"}, 16'(d_roll), m_roll);
        chk({pfx, "_yaw"}, 16'(d_yaw), m_yaw);
        chk({pfx, "_thrst"}, 16'(thrst), 16'(m_thr));
        chk({pfx, "_moff"}, 16'(motors_off), 16'(m_moff));
    endtask

    // mode 0: plain calibration; 1: SET_PITCH held during RAMP; 2: reset pulse while in CAL.
    task automatic cal_seq(input int mode);
        int cyc;
        int s1;
        s0 = n_send; c0 = n_clr; t0 = n_strt;
        @(posedge clk); #1;
        cmd_rdy = 1'b1; cmd = 8'h06; data = 16'h5A5A;
        @(posedge clk); #1;
        cmd_rdy = 1'b0;
        m_moff = 1'b0;
        chk("cal_inertial_on", 16'(inertial_cal), 16'd1);
        chk("cal_motors_on", 16'(motors_off), 16'd0);
        chk("cal_clr_once", 16'(n_clr - c0), 16'd1);
        chk("cal_no_early_resp", 16'(n_send - s0), 16'd0);
`ifndef FAST_SIM_EN
        force dut.r_tmr = '1;
`endif
        if (mode == 1) begin
            cmd_rdy = 1'b1; cmd = 8'h02; data = 16'h0123;
        end
        cyc = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (strt_cal) begin
                cyc = i;
                break;
            end
        end
        chk("strt_cal_latency", 16'(cyc), 16'(RAMP_CYC));
        @(posedge clk); #1;
`ifndef FAST_SIM_EN
        release dut.r_tmr;
`endif
        chk("cal_state_inertial", 16'(inertial_cal), 16'd1);
        chk("strt_cal_single", 16'(strt_cal), 16'd0);
        if (mode == 2) begin
            rst_n = 1'b0;
            #1;
            model_reset();
            chk("rst_inertial", 16'(inertial_cal), 16'd0);
            chk("rst_moff", 16'(motors_off), 16'd1);
            chk("rst_ptch", 16'(d_ptch), 16'd0);
            chk("rst_roll", 16'(d_roll), 16'd0);
            chk("rst_yaw", 16'(d_yaw), 16'd0);
            chk("rst_thrst", 16'(thrst), 16'd0);
            chk("rst_resp", 16'(resp), 16'h00A5);
            chk("rst_pulses", 16'({strt_cal, send_resp, clr_cmd_rdy}), 16'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            s1 = n_send;
            cal_done = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            cal_done = 1'b0;
            chk("rst_cal_done_no_resp", 16'(n_send - s1), 16'd0);
            chk("rst_cal_done_inertial", 16'(inertial_cal), 16'd0);
            return;
        end
        repeat (20) @(posedge clk);
        #1;
        chk("strt_cal_count", 16'(n_strt - t0), 16'd1);
        chk("cal_cmd_not_cleared", 16'(n_clr - c0), 16'd1);
        chk("cal_no_resp_yet", 16'(n_send - s0), 16'd0);
        chk("cal_ptch_held", 16'(d_ptch), m_ptch);
        cal_done = 1'b1;
        @(posedge clk); #1;
        cal_done = 1'b0;
        chk("cal_inertial_off", 16'(inertial_cal), 16'd0);
        chk("cal_ack_cnt", 16'(n_send - s0), 16'd1);
        chk("cal_ack_val", 16'(last_resp), 16'h00A5);
        if (mode == 1) begin
            @(posedge clk); #1;
            cmd_rdy = 1'b0;
            m_ptch = 16'h0123;
            chk("pend_ptch_applied", 16'(d_ptch), m_ptch);
            chk("pend_clr_cnt", 16'(n_clr - c0), 16'd2);
            chk("pend_ack_cnt", 16'(n_send - s0), 16'd2);
            chk("pend_ack_val", 16'(last_resp), 16'h00A5);
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [15:0] d;
        logic [15:0] e_ptch;
        logic [15:0] e_roll;
        logic [15:0] e_yaw;
        logic [8:0]  e_thr;
        logic        e_moff;
        logic [7:0]  e_resp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  er;
        logic [7:0]  op;
        logic [15:0] d;
        int          s1;

        tbl[0] = '{8'h05, 16'h00AA, 16'h0000, 16'h0000, 16'h0000, 9'h0AA, 1'b1, 8'hA5};
        tbl[1] = '{8'h02, 16'hFF9C, 16'hFF9C, 16'h0000, 16'h0000, 9'h0AA, 1'b1, 8'hA5};
        tbl[2] = '{8'h03, 16'h0066, 16'hFF9C, 16'h0066, 16'h0000, 9'h0AA, 1'b1, 8'hA5};
        tbl[3] = '{8'h04, 16'h0099, 16'hFF9C, 16'h0066, 16'h0099, 9'h0AA, 1'b1, 8'hA5};
        tbl[4] = '{8'h3C, 16'h1234, 16'hFF9C, 16'h0066, 16'h0099, 9'h0AA, 1'b1, 8'hEE};
        tbl[5] = '{8'h05, 16'hFFFF, 16'hFF9C, 16'h0066, 16'h0099, 9'h1FF, 1'b1, 8'hA5};
        tbl[6] = '{8'h07, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1, 8'hA5};
        tbl[7] = '{8'h08, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1, 8'hA5};

        rst_n = 1'b0; cmd_rdy = 1'b0; cmd = '0; data = '0; cal_done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ptch", 16'(d_ptch), 16'd0);
        chk("reset_thrst", 16'(thrst), 16'd0);
        chk("reset_moff", 16'(motors_off), 16'd1);
        chk("reset_resp", 16'(resp), 16'h00A5);
        chk("reset_pulses", 16'({strt_cal, inertial_cal, clr_cmd_rdy, send_resp}), 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply(tbl[i].op, tbl[i].d);
            model_cmd(tbl[i].op, tbl[i].d, er);
            chk($sformatf("tbl%0d_resp", i), 16'(last_resp), 16'(tbl[i].e_resp));
            chk($sformatf("tbl%0d_send_cnt", i), 16'(n_send - s0), 16'd1);
            chk($sformatf("tbl%0d_clr_cnt", i), 16'(n_clr - c0), 16'd1);
            chk($sformatf("tbl%0d_ptch", i), 16'(d_ptch), tbl[i].e_ptch);
            chk($sformatf("tbl%0d_roll", i), 16'(d_roll), tbl[i].e_roll);
            chk($sformatf("tbl%0d_yaw", i), 16'(d_yaw), tbl[i].e_yaw);
            chk($sformatf("tbl%0d_thrst", i), 16'(thrst), 16'(tbl[i].e_thr));
            chk($sformatf("tbl%0d_moff", i), 16'(motors_off), 16'(tbl[i].e_moff));
        end

        s1 = n_send;
        @(posedge clk); #1;
        cal_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cal_done = 1'b0;
        chk("idle_cal_done_ignored", 16'(n_send - s1), 16'd0);
        chk("idle_cal_done_inertial", 16'(inertial_cal), 16'd0);

        apply(8'h02, 16'h1111); model_cmd(8'h02, 16'h1111, er); chk_model("pre_cal_ptch", er);
        apply(8'h05, 16'h0050); model_cmd(8'h05, 16'h0050, er); chk_model("pre_cal_thr", er);
        cal_seq(0);

        apply(8'h07, 16'hBEEF); model_cmd(8'h07, 16'hBEEF, er); chk_model("eland", er);
        apply(8'h08, 16'h0000); model_cmd(8'h08, 16'h0000, er); chk_model("moff", er);

        cal_seq(1);

        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 9))
                0: op = 8'h02;
                1: op = 8'h03;
                2: op = 8'h04;
                3: op = 8'h05;
                4: op = 8'h07;
                5: op = 8'h08;
                default: op = 8'($urandom);
            endcase
            if (op == 8'h06) op = 8'hFF;
            d = 16'($urandom);
            apply(op, d);
            model_cmd(op, d, er);
            chk_model("rnd", er);
        end

        apply(8'h03, 16'h8001); model_cmd(8'h03, 16'h8001, er); chk_model("pre_rst_roll", er);
        apply(8'h05, 16'h0123); model_cmd(8'h05, 16'h0123, er); chk_model("pre_rst_thr", er);
        cal_seq(2);

        apply(8'h04, 16'h0042); model_cmd(8'h04, 16'h0042, er); chk_model("post_rst_yaw", er);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
